// File: rtl/dmem_responder_if.sv
// Load/store bus between a datapath data port (master) and the data-memory responder (slave).
interface dmem_responder_if;
    logic [2:0]  ReadControl;
    logic [2:0]  WriteControl;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        err;

    modport master (
        output ReadControl, WriteControl, addr, wdata,
        input  rdata, ready, err
    );

    modport slave (
        input  ReadControl, WriteControl, addr, wdata,
        output rdata, ready, err
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: latches one load/store, waits WAIT_CYCLES, then answers with a one-cycle ready.
// Define DMEM_USER_IO_EN to map a 32-bit user I/O register at USER_ADDR instead of RAM.
module dmem_responder #(
    parameter int          DEPTH       = 256,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] USER_ADDR   = 32'h0000_0400
) (
    input  logic             clk,
    input  logic             rst,
    dmem_responder_if.slave  bus,
    input  logic [6:0]       user_in,
    output logic [6:0]       user_out
);
    localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] MEM_BYTES = 32'(DEPTH * 4);
    localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [2:0] OP_LB  = 3'd1;
    localparam logic [2:0] OP_LH  = 3'd2;
    localparam logic [2:0] OP_LW  = 3'd3;
    localparam logic [2:0] OP_LBU = 3'd4;
    localparam logic [2:0] OP_LHU = 3'd5;
    localparam logic [2:0] OP_SB  = 3'd1;
    localparam logic [2:0] OP_SH  = 3'd2;
    localparam logic [2:0] OP_SW  = 3'd3;

    logic [1:0]    state_q, state_d;
    logic [3:0]    wait_cnt_q, wait_cnt_d;
    logic [2:0]    rd_op_q, wr_op_q;
    logic [1:0]    lane_q;
    logic [AW-1:0] idx_q;
    logic [31:0]   wdata_q;
    logic          err_q;
    logic          user_sel_q;
    logic [31:0]   rdata_hold_q;

    logic          rd_valid, wr_valid, accept;
    logic [2:0]    rd_op, wr_op;
    logic          is_half, is_word, misaligned, out_of_range, req_err;
    logic          user_hit;
    logic [31:0]   user_word;
    logic          resp_live;

    // Request decode; only meaningful while IDLE, ignored elsewhere.
    always_comb begin
        rd_valid     = bus.ReadControl inside {[3'd1:3'd5]};
        wr_valid     = bus.WriteControl inside {[3'd1:3'd3]};
        rd_op        = rd_valid ? bus.ReadControl : 3'd0;
        wr_op        = wr_valid ? bus.WriteControl : 3'd0;
        accept       = rd_valid | wr_valid;
        is_half      = (rd_op == OP_LH) || (rd_op == OP_LHU) || (wr_op == OP_SH);
        is_word      = (rd_op == OP_LW) || (wr_op == OP_SW);
        misaligned   = (is_half && bus.addr[0]) || (is_word && (bus.addr[1:0] != 2'b00));
        out_of_range = (bus.addr >= MEM_BYTES) && !user_hit;
        req_err      = (rd_valid && wr_valid) || misaligned || out_of_range;
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d    = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
                    wait_cnt_d = WAIT_LOAD;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // A reset landing in RESP must suppress the response and any write in that same cycle.
    assign resp_live = (state_q == ST_RESP) && !rst;

    // Store lane steering: data replicated across lanes, enables pick the addressed ones.
    logic [3:0]  byte_en;
    logic [31:0] wr_word;
    always_comb begin
        byte_en = 4'b0000;
        wr_word = wdata_q;
        case (wr_op_q)
            OP_SB: begin
                byte_en = 4'b0001 << lane_q;
                wr_word = {4{wdata_q[7:0]}};
            end
            OP_SH: begin
                byte_en = lane_q[1] ? 4'b1100 : 4'b0011;
                wr_word = {2{wdata_q[15:0]}};
            end
            OP_SW: begin
                byte_en = 4'b1111;
                wr_word = wdata_q;
            end
            default: begin
                byte_en = 4'b0000;
                wr_word = wdata_q;
            end
        endcase
    end

    logic          ram_we;
    logic [AW-1:0] rd_idx;
    logic [31:0]   ram_rd;

    assign ram_we = resp_live && !err_q && !user_sel_q && (wr_op_q != 3'd0);
    // Read address follows the bus while IDLE so data is ready even with zero wait cycles.
    assign rd_idx = (state_q == ST_IDLE) ? bus.addr[AW+1:2] : idx_q;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] rd_q;
            always_ff @(posedge clk) begin
                if (ram_we && byte_en[gi]) begin
                    mem[idx_q] <= wr_word[8*gi +: 8];
                end
                rd_q <= mem[rd_idx];
            end
            assign ram_rd[8*gi +: 8] = rd_q;
        end
    endgenerate

`ifdef DMEM_USER_IO_EN
    logic [31:0] user_q;
    logic        unused_user_hi;

    assign user_hit  = (bus.addr[31:2] == USER_ADDR[31:2]);
    assign user_word = {25'd0, user_in};
    assign user_out  = user_q[6:0];
    assign unused_user_hi = ^user_q[31:7];

    always_ff @(posedge clk) begin
        if (rst) begin
            user_q <= 32'd0;
        end else if (resp_live && !err_q && user_sel_q && (wr_op_q != 3'd0)) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    user_q[8*i +: 8] <= wr_word[8*i +: 8];
                end
            end
        end
    end
`else
    logic unused_cfg;

    assign user_hit   = 1'b0;
    assign user_word  = 32'd0;
    assign user_out   = 7'd0;
    assign unused_cfg = ^{user_in, USER_ADDR};
`endif

    logic [31:0] load_raw, shifted, load_val, rdata_resp;
    always_comb begin
        load_raw = user_sel_q ? user_word : ram_rd;
        shifted  = load_raw >> {lane_q, 3'b000};
        case (rd_op_q)
            OP_LB:   load_val = {{24{shifted[7]}}, shifted[7:0]};
            OP_LH:   load_val = {{16{shifted[15]}}, shifted[15:0]};
            OP_LBU:  load_val = {24'd0, shifted[7:0]};
            OP_LHU:  load_val = {16'd0, shifted[15:0]};
            default: load_val = load_raw;
        endcase
        if (err_q) begin
            rdata_resp = 32'd0;
        end else if (rd_op_q != 3'd0) begin
            rdata_resp = load_val;
        end else begin
            rdata_resp = rdata_hold_q;
        end
    end

    assign bus.rdata = resp_live ? rdata_resp : rdata_hold_q;
    assign bus.ready = resp_live;
    assign bus.err   = resp_live && err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            wait_cnt_q   <= 4'd0;
            rd_op_q      <= 3'd0;
            wr_op_q      <= 3'd0;
            lane_q       <= 2'd0;
            idx_q        <= '0;
            wdata_q      <= 32'd0;
            err_q        <= 1'b0;
            user_sel_q   <= 1'b0;
            rdata_hold_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if ((state_q == ST_IDLE) && accept) begin
                rd_op_q    <= rd_op;
                wr_op_q    <= wr_op;
                lane_q     <= bus.addr[1:0];
                idx_q      <= bus.addr[AW+1:2];
                wdata_q    <= bus.wdata;
                err_q      <= req_err;
                user_sel_q <= user_hit;
            end
            if (resp_live) begin
                rdata_hold_q <= rdata_resp;
            end
        end
    end
endmodule
